// File: rtl/traffic_pkg.sv
// traffic_pkg: light state encodings and default interval-timer constants shared by the traffic controller and timer
package traffic_pkg;
  localparam logic [1:0] s0 = 2'b00;
  localparam logic [1:0] s1 = 2'b01;
  localparam logic [1:0] s2 = 2'b10;
  localparam logic [1:0] s3 = 2'b11;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_SHORT_TICKS = 3;
  localparam int DEF_LONG_TICKS = 8;
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/traffic_interval_timer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every PRESCALE enabled cycles; ports clk, rst, clr (restart), en (count enable), tick
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  if (PRESCALE < 1) begin : g_bad
    $error("tick_prescaler: PRESCALE must be >= 1");
  end
  if (PRESCALE == 1) begin : g_unit
    assign tick = en & ~clr & ~rst;
  end else begin : g_cnt
    localparam int PW = cnt_width(PRESCALE);
    logic [PW-1:0] pre_cnt;
    assign tick = en & ~clr & ~rst & (pre_cnt == PW'(PRESCALE - 1));
    always_ff @(posedge clk)
      if (rst || clr) pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else if (en) pre_cnt <= pre_cnt + 1'b1;
  end
endmodule

// File: rtl/traffic_interval_timer.sv
// traffic_interval_timer: shared-counter interval timer; in clk, rst, st (restart), hold (freeze); out ts, tl (expiry levels), tick, elapsed
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int SHORT_TICKS = DEF_SHORT_TICKS,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int CW = $clog2(LONG_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          hold,
  output logic          ts,
  output logic          tl,
  output logic          tick,
  output logic [CW-1:0] elapsed
);
  if (PRESCALE < 1 || SHORT_TICKS < 1 || LONG_TICKS <= SHORT_TICKS) begin : g_bad
    $error("traffic_interval_timer: illegal PRESCALE/SHORT_TICKS/LONG_TICKS");
  end
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (st),
    .en  (~hold),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (rst || st) elapsed <= '0;
    else if (tick && elapsed != CW'(LONG_TICKS)) elapsed <= elapsed + 1'b1;
  // decoded from the flops alone: the controller closes a combinational loop st <- ts/tl
  assign ts = elapsed >= CW'(SHORT_TICKS);
  assign tl = elapsed >= CW'(LONG_TICKS);
endmodule

// File: tb/tb_traffic_interval_timer.sv
// tb_traffic_interval_timer: table-driven scoreboard bench for traffic_interval_timer (PRESCALE 4 and 1)
module tb_traffic_interval_timer;
  logic clk = 0, rst = 1, st = 0, hold = 0, armed = 0;
  logic ts, tl, tick, ts1, tl1, tick1;
  logic [3:0] elapsed, elapsed1, prev;
  int n_chk = 0, n_bad = 0;
  typedef struct {
    logic rst, st, hold;
    int   n, el;
    logic ts, tl, tick;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t v, e;
  always #5 clk = ~clk;
  traffic_interval_timer #(.PRESCALE(4), .SHORT_TICKS(3), .LONG_TICKS(8)) dut (
    .clk(clk), .rst(rst), .st(st), .hold(hold),
    .ts(ts), .tl(tl), .tick(tick), .elapsed(elapsed)
  );
  traffic_interval_timer #(.PRESCALE(1), .SHORT_TICKS(3), .LONG_TICKS(8)) dut1 (
    .clk(clk), .rst(rst), .st(st), .hold(hold),
    .ts(ts1), .tl(tl1), .tick(tick1), .elapsed(elapsed1)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, s, h, input int n, el, input logic t_s, t_l, tk);
    tbl.push_back('{r, s, h, n, el, t_s, t_l, tk});
  endtask
  always @(negedge clk)
    if (armed) begin
      chk("no_x", int'($isunknown({ts, tl, tick, elapsed, ts1, tl1, tick1, elapsed1})), 0);
      chk("tl_implies_ts", int'(tl & ~ts), 0);
      chk("elapsed_sat", int'(elapsed > 4'd8), 0);
    end
  initial begin
    // rst st hold  n  elapsed ts tl tick
    add(0, 0, 0,  11, 2, 0, 0, 1);
    add(0, 0, 0,   1, 3, 1, 0, 0);
    add(0, 0, 0,  19, 7, 1, 0, 1);
    add(0, 0, 0,   1, 8, 1, 1, 0);
    add(0, 0, 0, 100, 8, 1, 1, 0);
    add(0, 1, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,  20, 5, 1, 0, 0);
    add(0, 1, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,  11, 2, 0, 0, 1);
    add(0, 0, 0,   1, 3, 1, 0, 0);
    add(0, 1, 0,   5, 0, 0, 0, 0);
    add(0, 0, 0,  11, 2, 0, 0, 1);
    add(0, 0, 0,   1, 3, 1, 0, 0);
    add(0, 1, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,   8, 2, 0, 0, 0);
    add(0, 0, 1,  10, 2, 0, 0, 0);
    add(0, 0, 0,   3, 2, 0, 0, 1);
    add(0, 0, 0,   1, 3, 1, 0, 0);
    add(0, 1, 1,   1, 0, 0, 0, 0);
    add(0, 0, 0,  24, 6, 1, 0, 0);
    add(1, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 0,  12, 3, 1, 0, 0);
    add(0, 0, 0,  20, 8, 1, 1, 0);
    repeat (3) cyc();
    chk("reset_elapsed", int'(elapsed), 0);
    chk("reset_ts", int'(ts), 0);
    chk("reset_tl", int'(tl), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_elapsed_p1", int'(elapsed1), 0);
    chk("reset_tick_p1", int'(tick1), 0);
    armed = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst = v.rst;
      st = v.st;
      hold = v.hold;
      sb.push_back(v);
      for (int k = 0; k < v.n; k++) begin
        prev = elapsed;
        cyc();
        if (v.rst || v.st) begin
          chk($sformatf("v%0d_restart_elapsed", i), int'(elapsed), 0);
          chk($sformatf("v%0d_restart_tick", i), int'(tick), 0);
        end else if (v.hold) begin
          chk($sformatf("v%0d_hold_elapsed", i), int'(elapsed), int'(prev));
          chk($sformatf("v%0d_hold_tick", i), int'(tick), 0);
        end
      end
      e = sb.pop_front();
      chk($sformatf("v%0d_elapsed", i), int'(elapsed), e.el);
      chk($sformatf("v%0d_ts", i), int'(ts), int'(e.ts));
      chk($sformatf("v%0d_tl", i), int'(tl), int'(e.tl));
      chk($sformatf("v%0d_tick", i), int'(tick), int'(e.tick));
    end
    rst = 1;
    st = 0;
    hold = 0;
    cyc();
    chk("rst_mid_ts_p1", int'(ts1), 0);
    chk("rst_mid_tl_p1", int'(tl1), 0);
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("p1_e%0d_ts", k), int'(ts1), int'(k >= 3));
      chk($sformatf("p1_e%0d_tl", k), int'(tl1), int'(k >= 8));
      chk($sformatf("p1_e%0d_tick", k), int'(tick1), 1);
      chk($sformatf("p1_e%0d_elapsed", k), int'(elapsed1), (k < 8) ? k : 8);
      chk($sformatf("p4_e%0d_tick", k), int'(tick), int'(k % 4 == 3));
      chk($sformatf("p4_e%0d_elapsed", k), int'(elapsed), k / 4);
    end
    hold = 1;
    cyc();
    chk("p1_hold_tick", int'(tick1), 0);
    chk("p1_hold_tl", int'(tl1), 1);
    hold = 0;
    st = 1;
    cyc();
    chk("p1_st_tick", int'(tick1), 0);
    chk("p1_st_ts", int'(ts1), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
